// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared types, FSM states and init ROM for the LCD SPI command sequencer
package lcd_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        INIT  = 2'd3
    } state_e;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } entry_t;

    localparam int INIT_LEN = 5;

    // Panel bring-up: SWRESET, SLPOUT, COLMOD=0x55 (16bpp), DISPON
    function automatic entry_t init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return entry_t'({1'b0, 8'h01});
            3'd1:    return entry_t'({1'b0, 8'h11});
            3'd2:    return entry_t'({1'b0, 8'h3A});
            3'd3:    return entry_t'({1'b1, 8'h55});
            3'd4:    return entry_t'({1'b0, 8'h29});
            default: return entry_t'(9'h000);
        endcase
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// rtl/lcd_cmd_fifo.sv - synchronous FIFO of {dc,data} entries with occupancy count
module lcd_cmd_fifo
    import lcd_spi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  entry_t                   wdata_i,
    output entry_t                   rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/lcd_spi_cmd_seq.sv
// rtl/lcd_spi_cmd_seq.sv - FIFO-fed byte sequencer for the LCD SPI master; LCD_INIT_ROM_EN adds a post-reset init ROM
module lcd_spi_cmd_seq
    import lcd_spi_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int XFER_CYCLES = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     wr_dc,
    input  logic [7:0]               wr_data,
    output logic                     spi_load,
    output logic [15:0]              spi_in,
    output logic                     lcd_dcx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            dcx_q, dcx_d;
    logic            load_q;
    logic            busy_q;
    logic            push, pop, full, empty;
    logic            fifo_nonempty_d;
    entry_t          head;

`ifdef LCD_INIT_ROM_EN
    logic [2:0]      rom_idx_q, rom_idx_d;
    entry_t          rom_entry;
    assign rom_entry = init_rom(rom_idx_q);
`endif

    assign wr_ready = !full;
    assign push     = wr_valid && wr_ready;

    lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry_t'({wr_dc, wr_data})),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Occupancy after this edge, so the registered busy tracks current state/count
    assign fifo_nonempty_d = push || (!empty && !(fifo_count == 1 && pop));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        dcx_d   = dcx_q;
        pop     = 1'b0;
`ifdef LCD_INIT_ROM_EN
        rom_idx_d = rom_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    byte_d  = head.data;
                    dcx_d   = head.dc;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = XFER;
            end
            XFER: begin
                if (cnt_q == CW'(XFER_CYCLES - 1)) begin
`ifdef LCD_INIT_ROM_EN
                    state_d = (rom_idx_q < 3'(INIT_LEN)) ? INIT : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            INIT: begin
`ifdef LCD_INIT_ROM_EN
                byte_d    = rom_entry.data;
                dcx_d     = rom_entry.dc;
                rom_idx_d = rom_idx_q + 3'd1;
                state_d   = SETUP;
`else
                state_d   = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_ROM_EN
            state_q   <= INIT;
            rom_idx_q <= '0;
`else
            state_q   <= IDLE;
`endif
            cnt_q  <= '0;
            byte_q <= '0;
            dcx_q  <= 1'b1;
            load_q <= 1'b1;
            busy_q <= 1'b0;
        end else begin
`ifdef LCD_INIT_ROM_EN
            rom_idx_q <= rom_idx_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            dcx_q   <= dcx_d;
            load_q  <= (state_d != XFER);
            busy_q  <= (state_d != IDLE) || fifo_nonempty_d;
        end
    end

    assign spi_load = load_q;
    assign spi_in   = {8'h00, byte_q};
    assign lcd_dcx  = dcx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_spi_cmd_seq.sv
// tb/tb_lcd_spi_cmd_seq.sv - directed self-checking bench for lcd_spi_cmd_seq
module tb_lcd_spi_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_dc;
    logic [7:0]  wr_data;
    logic        spi_load;
    logic [15:0] spi_in;
    logic        lcd_dcx;
    logic        busy;
    logic [3:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    lcd_spi_cmd_seq #(.DEPTH(8), .XFER_CYCLES(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_dc      (wr_dc),
        .wr_data    (wr_data),
        .spi_load   (spi_load),
        .spi_in     (spi_in),
        .lcd_dcx    (lcd_dcx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts high cycles until spi_load falls; leaves sampling in the first low cycle
    task automatic wait_window(output int gap);
        gap = 0;
        while (spi_load !== 1'b0 && gap < 300) begin
            gap++;
            tick();
        end
        chk("window_start", {31'd0, spi_load}, 32'd0);
    endtask

    // Counts low cycles; leaves sampling in the first high cycle after the window
    task automatic count_low(output int n);
        n = 0;
        while (spi_load === 1'b0 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic rom_check();
        logic [7:0] rom_b [5];
        logic       rom_d [5];
        int g, n;
        rom_b[0] = 8'h01; rom_b[1] = 8'h11; rom_b[2] = 8'h3A; rom_b[3] = 8'h55; rom_b[4] = 8'h29;
        rom_d[0] = 1'b0;  rom_d[1] = 1'b0;  rom_d[2] = 1'b0;  rom_d[3] = 1'b1;  rom_d[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_window(g);
            chk("rom_byte", {16'd0, spi_in}, {24'd0, rom_b[k]});
            chk("rom_dcx", {31'd0, lcd_dcx}, {31'd0, rom_d[k]});
            chk("rom_busy", {31'd0, busy}, 32'd1);
            count_low(n);
            chk("rom_len", n, 18);
        end
    endtask

    initial begin
        int g, n, pushed, sent, lows;
        logic prev_load, acc;
        logic [7:0] exp_b [8];
        logic       exp_d [8];

        rst = 1'b1; wr_valid = 1'b0; wr_dc = 1'b0; wr_data = 8'h00;
        repeat (3) tick();
        chk("rst_spi_load", {31'd0, spi_load}, 32'd1);
        chk("rst_spi_in", {16'd0, spi_in}, 32'h0);
        chk("rst_lcd_dcx", {31'd0, lcd_dcx}, 32'd1);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
`ifdef LCD_INIT_ROM_EN
        rom_check();
        tick();
`endif
        tick();

        // Single byte
        wr_valid = 1'b1; wr_dc = 1'b0; wr_data = 8'h2C;
        tick();
        wr_valid = 1'b0;
        chk("single_count", {28'd0, fifo_count}, 32'd1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("single_setup_load", {31'd0, spi_load}, 32'd1);
        chk("single_spi_in", {16'd0, spi_in}, 32'h002C);
        chk("single_dcx", {31'd0, lcd_dcx}, 32'd0);
        chk("single_popped", {28'd0, fifo_count}, 32'd0);
        tick();
        chk("single_load_fall", {31'd0, spi_load}, 32'd0);
        count_low(n);
        chk("single_len", n, 18);
        chk("single_busy_idle", {31'd0, busy}, 32'd0);
        chk("single_dcx_hold", {31'd0, lcd_dcx}, 32'd0);
        tick();

        // Burst of 8 data bytes 00..07
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_dc = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("burst_count", {28'd0, fifo_count}, 32'd7);
        chk("burst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("burst_b0", {16'd0, spi_in}, 32'h0000);
        chk("burst_d0", {31'd0, lcd_dcx}, 32'd1);
        count_low(n);
        chk("burst_len0_rest", n, 13);
        for (int i = 1; i < 8; i++) begin
            wait_window(g);
            chk("burst_gap", g, 2);
            chk("burst_byte", {16'd0, spi_in}, i);
            chk("burst_dcx", {31'd0, lcd_dcx}, 32'd1);
            count_low(n);
            chk("burst_len", n, 18);
        end
        chk("burst_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Fill to full during a transfer, then hold wr_valid
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1; wr_dc = i[0]; wr_data = 8'h40 + 8'(i);
            tick();
        end
        chk("full_count", {28'd0, fifo_count}, 32'd8);
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        wr_dc = 1'b1; wr_data = 8'h50;
        g = 0;
        while (spi_load === 1'b0 && g < 100) begin
            g++;
            tick();
            if (spi_load === 1'b0)
                chk("full_hold", {28'd0, fifo_count}, 32'd8);
        end
        chk("full_idle_count", {28'd0, fifo_count}, 32'd8);
        tick();
        chk("full_pop_edge", {28'd0, fifo_count}, 32'd7);
        tick();
        chk("full_refill", {28'd0, fifo_count}, 32'd8);
        wr_valid = 1'b0;
        chk("full_b1", {16'd0, spi_in}, 32'h0041);
        chk("full_d1", {31'd0, lcd_dcx}, 32'd1);
        count_low(n);
        for (int i = 0; i < 7; i++) begin
            exp_b[i] = 8'h42 + 8'(i);
            exp_d[i] = i[0];
        end
        exp_b[7] = 8'h50; exp_d[7] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_window(g);
            chk("full_gap", g, 2);
            chk("full_byte", {16'd0, spi_in}, {24'd0, exp_b[i]});
            chk("full_dcx", {31'd0, lcd_dcx}, {31'd0, exp_d[i]});
            count_low(n);
        end
        chk("full_drained", {28'd0, fifo_count}, 32'd0);
        tick();

        // 20 bytes through the FIFO with concurrent push and drain
        pushed = 0; sent = 0; prev_load = spi_load;
        for (int cyc = 0; cyc < 1000 && sent < 20; cyc++) begin
            wr_valid = (pushed < 20);
            wr_data  = 8'h90 + 8'(pushed * 7);
            wr_dc    = ((pushed % 3) == 0);
            acc      = wr_valid && wr_ready;
            tick();
            if (acc) pushed++;
            if (prev_load === 1'b1 && spi_load === 1'b0) begin
                chk("wrap_byte", {16'd0, spi_in}, {24'd0, 8'h90 + 8'(sent * 7)});
                chk("wrap_dcx", {31'd0, lcd_dcx}, {31'd0, ((sent % 3) == 0)});
                sent++;
            end
            prev_load = spi_load;
        end
        wr_valid = 1'b0;
        chk("wrap_pushed", pushed, 20);
        chk("wrap_sent", sent, 20);
        count_low(n);
        chk("wrap_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Reset mid-transfer with 3 bytes queued
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_dc = 1'b0; wr_data = 8'hE0 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        chk("mid_queued", {28'd0, fifo_count}, 32'd3);
        repeat (6) tick();
        chk("mid_in_xfer", {31'd0, spi_load}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_load", {31'd0, spi_load}, 32'd1);
        chk("mid_rst_count", {28'd0, fifo_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
`ifdef LCD_INIT_ROM_EN
        rom_check();
`endif
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (spi_load === 1'b0) lows++;
        end
        chk("mid_no_resend", lows, 0);
        chk("mid_busy_end", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
